pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Multi-channel, parametrised pulse stretcher for the PUF control path; converts short or level trigger events into output pulses of programmable length.
- Each channel runs independently: runtime length, selectable edge/level triggering, optional retrigger, per-channel completion strobe.
- Sits between RO-PUF measurement/control logic and downstream enables, counters and LEDs needing a guaranteed-width pulse.

Parameters:
- CHANNELS, 4, number of independent stretcher channels (>=1).
- CNT_W, 8, width of the pulse-length value and internal counters.
- EDGE_TRIG, 1, 1 = trigger on rising edge of in[i]; 0 = trigger while in[i] is high.
- RETRIG, 0, 1 = a trigger during an active pulse restarts the length count; 0 = triggers during an active pulse are ignored.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global trigger enable; 0 blocks new triggers, active pulses complete normally.
- len  input  CNT_W  pulse length in clk cycles, shared by all channels, sampled per channel at trigger.
- in  input  CHANNELS  per-channel trigger inputs, clk-synchronous.
- out  output  CHANNELS  stretched pulses, registered.
- done  output  CHANNELS  one-cycle strobe per channel at pulse end.
- busy  output  1  OR of all out bits, registered.

Behaviour:
- Reset (rst=1 at a posedge): out=0, done=0, busy=0, all counters=0, all channels IDLE, edge-detect history=0. Takes priority over every other event; a pulse in progress is truncated.
- Edge-detect history resets to 0, so with EDGE_TRIG=1 an in[i] held high across reset release counts as a rising edge on the first cycle after reset.
- Trigger: trig[i] = en & (EDGE_TRIG ? in[i] & ~in_q[i] : in[i]); in_q[i] is in[i] delayed one cycle, updated every cycle regardless of en.
- Effective length: L = (len==0) ? 1 : len. A length of 0 is never an empty pulse.
- Per-channel FSM states: IDLE, HIGH.
- IDLE, trig at edge k: out[i]=1 after edge k; counter <= L-1; state becomes HIGH. Output latency is one clock, i.e. out is visible after the same edge that samples the trigger.
- HIGH, counter!=0: counter decrements; out stays 1.
- HIGH, counter==0: state returns to IDLE; out[i]=0 and done[i]=1 at that edge, so out stays high for exactly L cycles. done[i] is 0 on the following cycle unless another end occurs.
- HIGH with trig and RETRIG=1: counter <= L-1 using the current len; out stays 1; no done. This has priority over the counter==0 end, so a trigger on the last cycle extends the pulse seamlessly.
- HIGH with trig and RETRIG=0: trigger ignored.
  - EDGE_TRIG=1: the edge is lost.
  - EDGE_TRIG=0: a still-high in[i] restarts the pulse after exactly one low cycle of out[i].
- Changing len mid-pulse has no effect on the running count.
- Deasserting en mid-pulse has no effect on the running count.
- busy is registered as the OR of next-state out bits, so it is cycle-aligned with out.
- Counter arithmetic is unsigned CNT_W bits; the decrement never wraps because a counter at 0 always exits HIGH.
- Maximum pulse length is 2^CNT_W - 1 cycles.

Optional Feature:
- Macro: PULSE_STRETCHER_SYNC_EN.
- Defined: each in[i] passes through a 2-flop synchronizer (reset to 0) before edge detect and trigger logic. This adds 2 cycles of trigger-to-out latency, and in may be asynchronous.
- Undefined: in is used directly; zero added latency; in must be clk-synchronous.

Test Plan:
- Reset and length: CHANNELS=4, EDGE_TRIG=1, RETRIG=0, len=5. Release rst with in=0, then pulse in[0] high for 1 cycle at edge k -> out[0]=1 for exactly 5 cycles (edges k..k+4), done[0]=1 for one cycle at edge k+5, busy mirrors out[0], other channels stay 0.
- Zero length and max length: len=0, single trigger -> out high exactly 1 cycle with done at the next edge. len=255, single trigger -> out high exactly 255 cycles.
- Retrigger: RETRIG=1, len=4. Trigger at edge k, second edge at k+3 (last high cycle) -> out continuous high for 7 cycles, single done at k+7. Repeat with RETRIG=0 -> 4-cycle pulse, second edge lost, one done.
- Level mode: EDGE_TRIG=0, RETRIG=0, len=3, in[1] held high for 10 cycles -> out[1] pattern 1,1,1,0,1,1,1,0,... with a done on each 0 cycle. Same stimulus with en=0 -> no pulses.
- Independence and simultaneity: triggers on all 4 channels in the same cycle with len=2, then len changed to 6 mid-pulse -> all four outputs give 2-cycle pulses with simultaneous done. A later trigger on ch2 gives a 6-cycle pulse while other channels stay low.
- Reset mid-pulse: len=20, trigger, assert rst at the 5th high cycle -> out, done and busy are 0 after that edge, no done strobe. With PULSE_STRETCHER_SYNC_EN defined, rerun the first scenario and expect out to rise 2 cycles later with the same 5-cycle width.

Source files
------------

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: per-channel trigger -> output pulse of len cycles (len 0 acts as 1); macro PULSE_STRETCHER_SYNC_EN adds a 2-flop input synchronizer.
// Latency: out rises after the edge that samples the trigger (+2 edges with PULSE_STRETCHER_SYNC_EN).
// Backpressure: none; a trigger during a pulse restarts it (RETRIG=1) or is dropped (RETRIG=0).
module pulse_stretcher #(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 8,
   parameter int EDGE_TRIG = 1,
   parameter int RETRIG    = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CNT_W-1:0]    len,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] done,
   output logic                busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HIGH = 1'b1
   } state_t;

   state_t              state_q [CHANNELS];
   state_t              state_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];

   logic [CHANNELS-1:0] in_s;
   logic [CHANNELS-1:0] in_q;
   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] out_d;
   logic [CHANNELS-1:0] done_d;
   logic [CNT_W-1:0]    len_eff;
   logic [CNT_W-1:0]    reload;

`ifdef PULSE_STRETCHER_SYNC_EN
   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in;
         sync2 <= sync1;
      end
   end

   assign in_s = sync2;
`else
   assign in_s = in;
`endif

   // Edge history tracks the input even while en is low, so re-enabling never fabricates an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= '0;
      end else begin
         in_q <= in_s;
      end
   end

   assign trig    = (EDGE_TRIG != 0) ? ({CHANNELS{en}} & in_s & ~in_q)
                                     : ({CHANNELS{en}} & in_s);
   assign len_eff = (len == '0) ? CNT_W'(1) : len;
   assign reload  = len_eff - CNT_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next-state logic; a retrigger takes priority over the terminal count.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (trig[i]) begin
                  state_d[i] = ST_HIGH;
                  cnt_d[i]   = reload;
               end
            end
            ST_HIGH: begin
               if (trig[i] && (RETRIG != 0)) begin
                  cnt_d[i] = reload;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = ST_IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Output logic, computed from the next state so registered outputs align with the state.
   always_comb begin
      out_d  = '0;
      done_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         out_d[i]  = (state_d[i] == ST_HIGH);
         done_d[i] = (state_q[i] == ST_HIGH) && (state_d[i] == ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out  <= '0;
         done <= '0;
         busy <= 1'b0;
      end else begin
         out  <= out_d;
         done <= done_d;
         busy <= |out_d;
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three instances (edge/no-retrig, edge/retrig, level/no-retrig) share stimulus
// and are compared every cycle against a remaining-cycles reference model, plus directed pulse-width checks.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] len;
   logic [3:0] in;

   logic [3:0] out_a  [3];
   logic [3:0] done_a [3];
   logic       busy_a [3];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: cycles of high output still to come, per instance and channel
   int         rem    [3][4];
   logic [3:0] m_done [3];
   logic [3:0] m_prev;
   logic [3:0] m_s1;
   logic [3:0] m_s2;

   always #5 clk = ~clk;

   pulse_stretcher #(.CHANNELS(4), .CNT_W(8), .EDGE_TRIG(1), .RETRIG(0)) dut_e (
      .clk(clk), .rst(rst), .en(en), .len(len), .in(in),
      .out(out_a[0]), .done(done_a[0]), .busy(busy_a[0]));

   pulse_stretcher #(.CHANNELS(4), .CNT_W(8), .EDGE_TRIG(1), .RETRIG(1)) dut_r (
      .clk(clk), .rst(rst), .en(en), .len(len), .in(in),
      .out(out_a[1]), .done(done_a[1]), .busy(busy_a[1]));

   pulse_stretcher #(.CHANNELS(4), .CNT_W(8), .EDGE_TRIG(0), .RETRIG(0)) dut_l (
      .clk(clk), .rst(rst), .en(en), .len(len), .in(in),
      .out(out_a[2]), .done(done_a[2]), .busy(busy_a[2]));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
      end
   endtask

   // One clock: advance the model on the edge, then compare every instance just after it.
   task automatic tick();
      logic [3:0] eff;
      logic [3:0] trig;
      logic [3:0] exp_out;
      logic       edge_mode;
      logic       retrig_mode;
      int         l;
      string      nm;
      @(posedge clk);
      l = (len == 8'd0) ? 1 : int'(len);
`ifdef PULSE_STRETCHER_SYNC_EN
      eff = m_s2;
`else
      eff = in;
`endif
      for (int d = 0; d < 3; d++) begin
         edge_mode   = (d != 2);
         retrig_mode = (d == 1);
         m_done[d]   = 4'b0;
         if (rst) begin
            for (int c = 0; c < 4; c++) rem[d][c] = 0;
         end else begin
            trig = en ? (edge_mode ? (eff & ~m_prev) : eff) : 4'b0;
            for (int c = 0; c < 4; c++) begin
               if (rem[d][c] == 0) begin
                  if (trig[c]) rem[d][c] = l;
               end else if (trig[c] && retrig_mode) begin
                  rem[d][c] = l;
               end else begin
                  rem[d][c]--;
                  if (rem[d][c] == 0) m_done[d][c] = 1'b1;
               end
            end
         end
      end
      if (rst) begin
         m_prev = 4'b0;
         m_s2   = 4'b0;
         m_s1   = 4'b0;
      end else begin
         m_prev = eff;
         m_s2   = m_s1;
         m_s1   = in;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         nm = (d == 0) ? "edge" : (d == 1) ? "retrig" : "level";
         for (int c = 0; c < 4; c++) exp_out[c] = (rem[d][c] > 0);
         check({nm, "_out"},  32'(out_a[d]),  32'(exp_out));
         check({nm, "_done"}, 32'(done_a[d]), 32'(m_done[d]));
         check({nm, "_busy"}, 32'(busy_a[d]), 32'(|exp_out));
      end
   endtask

   initial begin
      int w0;
      int w1;
      int w2;
      m_prev = '0;
      m_s1   = '0;
      m_s2   = '0;
      for (int d = 0; d < 3; d++) begin
         m_done[d] = '0;
         for (int c = 0; c < 4; c++) rem[d][c] = 0;
      end

      // reset state
      rst = 1'b1; en = 1'b1; len = 8'd5; in = 4'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // single-cycle trigger, len 5
      w0 = 0; w2 = 0;
      in = 4'b0001; tick(); w0 += int'(out_a[0][0]); w2 += int'(out_a[2][0]);
      in = 4'b0000;
      repeat (10) begin tick(); w0 += int'(out_a[0][0]); w2 += int'(out_a[2][0]); end
      check("width_len5_edge", w0, 5);
      check("width_len5_level", w2, 5);

      // len 0 acts as 1, then maximum length
      len = 8'd0; w0 = 0;
      in = 4'b0001; tick(); w0 += int'(out_a[0][0]);
      in = 4'b0000;
      repeat (6) begin tick(); w0 += int'(out_a[0][0]); end
      check("width_len0", w0, 1);
      len = 8'd255; w0 = 0;
      in = 4'b0001; tick(); w0 += int'(out_a[0][0]);
      in = 4'b0000;
      repeat (262) begin tick(); w0 += int'(out_a[0][0]); end
      check("width_len255", w0, 255);

      // second edge on the last high cycle: extends with RETRIG=1, lost with RETRIG=0
      len = 8'd4; w0 = 0; w1 = 0;
      in = 4'b0001; tick(); w0 += int'(out_a[0][0]); w1 += int'(out_a[1][0]);
      in = 4'b0000;
      repeat (2) begin tick(); w0 += int'(out_a[0][0]); w1 += int'(out_a[1][0]); end
      in = 4'b0001; tick(); w0 += int'(out_a[0][0]); w1 += int'(out_a[1][0]);
      in = 4'b0000;
      repeat (12) begin tick(); w0 += int'(out_a[0][0]); w1 += int'(out_a[1][0]); end
      check("width_retrig_on", w1, 7);
      check("width_retrig_off", w0, 4);

      // level mode held high, then the same with en low
      len = 8'd3;
      in = 4'b0010; repeat (10) tick();
      in = 4'b0000; repeat (6) tick();
      en = 1'b0; w2 = 0;
      in = 4'b0010; repeat (10) begin tick(); w2 += int'(out_a[2][1]); end
      in = 4'b0000; repeat (4) tick();
      check("width_en_low", w2, 0);
      en = 1'b1;

      // all channels together, len changed mid-pulse, then ch2 alone
      len = 8'd2;
      in = 4'b1111; tick();
      len = 8'd6; in = 4'b0000;
      repeat (6) tick();
      w0 = 0;
      in = 4'b0100; tick(); w0 += int'(out_a[0][2]);
      in = 4'b0000;
      repeat (10) begin tick(); w0 += int'(out_a[0][2]); end
      check("width_len6_ch2", w0, 6);

      // reset mid-pulse
      len = 8'd20;
      in = 4'b0001; tick();
      in = 4'b0000; repeat (4) tick();
      rst = 1'b1; tick();
      rst = 1'b0; repeat (25) tick();

      // randomized traffic
      repeat (1500) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
         in  = 4'($urandom & $urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
